afu_csr: RTL and testbench
==========================

# afu_csr

MMIO control/status register block for the AFU. It sits directly downstream of the registered CCI-P RX bundle inside `afu`. It decodes host MMIO reads and writes arriving on RX channel c0, returns read data on TX channel c2, and exposes a start/buffer-address/status interface to the AFU datapath engine. All host-visible configuration and completion status passes through this block.

## Interface
- `AFU_ID`, 128'h0: AFU GUID returned at 0x008 (low) and 0x010 (high).
- `AFU_DFH`, 64'h1000_0000_0000_0000: value returned at 0x000.
- `clk`  in  1  AFU clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  t_if_ccip_Rx  registered CCI-P RX; uses `c0.mmioRdValid`, `c0.mmioWrValid`, `c0.hdr` (as t_ccip_c0_ReqMmioHdr), `c0.data[63:0]`.
- `tx_c2`  out  t_if_ccip_c2_Tx  MMIO read response: `mmioRdValid`, `hdr.tid`, `data`.
- `buf_addr`  out  t_ccip_clAddr  cache-line base address for the engine.
- `start`  out  1  single-cycle start pulse to the engine.
- `busy`  in  1  engine running.
- `done`  in  1  single-cycle engine completion pulse.

## Operation
- Byte offset = `hdr.address` << 2. Qword index = `hdr.address[15:1]`. Only offsets 0x000–0x040 are decoded.
- Register map:
  - 0x000 DFH: RO, returns `AFU_DFH`.
  - 0x008 and 0x010: RO, return `AFU_ID[63:0]` and `AFU_ID[127:64]`.
  - 0x018 and 0x020: RO, return 0.
  - 0x028 SCRATCH: RW, 64 bits.
  - 0x030 BUF_ADDR: RW. Bits [41:0] drive `buf_addr`; upper bits read back 0.
  - 0x038 CTRL: WO, reads 0. bit0 = start, bit1 = clear.
  - 0x040 STATUS: RO. bit0 = busy, bit1 = done_flag, bit2 = err_flag, [63:32] = run_cnt.
- Undecoded offsets read 0; writes to them are dropped.
- Write length:
  - `hdr.length`==1 (8B) writes all 64 bits.
  - `hdr.length`==0 (4B) writes `data[31:0]` into the half selected by `hdr.address[0]`: 0 = low half, 1 = high half.
  - Other length values are treated as 8B.
- Reads always return the full aligned qword; the host selects the half it needs.
- CTRL start:
  - If `busy`==0, `start` pulses one cycle later.
  - If `busy`==1, no pulse is issued and err_flag is set.
- CTRL clear zeroes done_flag, err_flag and run_cnt.
- `done` pulse sets done_flag and increments run_cnt. run_cnt wraps from 0xFFFF_FFFF to 0.
- Same-cycle `done` and clear: the set wins, giving done_flag=1 and run_cnt=1.
- Same-cycle start and clear in one write: both take effect.
- Read responses go out in request order. No read is ever dropped.

## Timing
- Reset values: `tx_c2.mmioRdValid`=0, `tx_c2.hdr`=0, `tx_c2.data`=0, `start`=0, `buf_addr`=0. SCRATCH, flags and run_cnt are all 0.
- Read latency is exactly 1 cycle. `mmioRdValid` at cycle N gives `tx_c2.mmioRdValid`=1 at N+1, with `tid` equal to the request tid. No backpressure exists on c2.
- Back-to-back reads on consecutive cycles give responses on consecutive cycles.
- Register writes take effect at N+1. A read at N+1 returns the new value.
- STATUS reads sample `busy`, the flags and run_cnt at cycle N, before any update made in cycle N.
- `start` is registered and asserts at N+1 for exactly one cycle.
- Reset is asynchronous. Asserting `rst_n` low mid-response deasserts `mmioRdValid` immediately. Any in-flight response is discarded; the host handles this through its own timeout.

## Structure
- Shared package `afu_csr_pkg` holds:
  - byte-offset localparams `CSR_DFH` … `CSR_STATUS`;
  - CTRL/STATUS bit-index localparams;
  - the default DFH constant.
- Single module with no sub-module. The decode and response register are small enough to stay flat.

## Test plan
- Reset, then read 0x000, 0x008, 0x010 with tids 5, 6, 7 -> responses on consecutive cycles with tids 5, 6, 7 and data `AFU_DFH`, `AFU_ID[63:0]`, `AFU_ID[127:64]`.
- 8B write 0xDEAD_BEEF_0123_4567 to 0x028, then 4B write 0xAAAA_AAAA to the high half (address 0x00B) -> read of 0x028 returns 0xAAAA_AAAA_0123_4567.
- Write 0x1234 to 0x030, then CTRL=1 with `busy`=0 -> `buf_addr`=0x1234 and `start` high for exactly one cycle. Repeat with `busy`=1 -> no pulse and STATUS=0x5.
- Three `done` pulses -> STATUS=0x0000_0003_0000_0002. Then CTRL=2 in the same cycle as a `done` -> STATUS=0x0000_0001_0000_0002.
- Read 0x100 (undecoded) -> data 0. Write 0x100 followed by a full register sweep -> no register changed.
- Assert `rst_n` low in the cycle after a read request -> `mmioRdValid` falls within the same cycle and all registers read 0 after release.

Source files
------------

// File: rtl/afu_csr_pkg.sv
// afu_csr_pkg: CCI-P MMIO subset types, CSR offsets, bit indices and write-mask helper for afu_csr
package afu_csr_pkg;
  typedef logic [41:0] t_ccip_clAddr;
  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;
  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;
  typedef struct packed {
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;
  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;
  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;
  localparam logic [17:0] CSR_DFH      = 18'h000;
  localparam logic [17:0] CSR_ID_L     = 18'h008;
  localparam logic [17:0] CSR_ID_H     = 18'h010;
  localparam logic [17:0] CSR_RSVD0    = 18'h018;
  localparam logic [17:0] CSR_RSVD1    = 18'h020;
  localparam logic [17:0] CSR_SCRATCH  = 18'h028;
  localparam logic [17:0] CSR_BUF_ADDR = 18'h030;
  localparam logic [17:0] CSR_CTRL     = 18'h038;
  localparam logic [17:0] CSR_STATUS   = 18'h040;
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_ERR   = 2;
  localparam logic [63:0] DFH_DEFAULT = 64'h1000_0000_0000_0000;
  // Byte-lane mask of an MMIO write: 4B writes touch only the half picked by address[0].
  function automatic logic [63:0] csr_wmask(input logic [1:0] len, input logic hi);
    return len == 2'd0 ? (hi ? 64'hFFFF_FFFF_0000_0000 : 64'h0000_0000_FFFF_FFFF) : '1;
  endfunction
endpackage

// File: rtl/afu_csr_if.sv
// afu_csr_if: MMIO bus bundle; rx carries host requests on c0, tx_c2 carries read responses
interface afu_csr_if;
  import afu_csr_pkg::*;
  t_if_ccip_Rx    rx;
  t_if_ccip_c2_Tx tx_c2;
  modport master (output rx, input tx_c2);
  modport slave  (input rx, output tx_c2);
endinterface

// File: rtl/afu_csr.sv
// afu_csr: MMIO CSR block; ports clk, rst_n, bus (rx in / tx_c2 out), buf_addr, start out, busy, done in
module afu_csr
  import afu_csr_pkg::*;
#(
  parameter logic [127:0] AFU_ID  = '0,
  parameter logic [63:0]  AFU_DFH = DFH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  afu_csr_if.slave     bus,
  output t_ccip_clAddr buf_addr,
  output logic         start,
  input  logic         busy,
  input  logic         done
);
  t_ccip_c0_ReqMmioHdr hdr;
  t_if_ccip_c2_Tx      tx_q, tx_d;
  logic [63:0]         scratch_q, scratch_d, rd_data, wmask, wval;
  t_ccip_clAddr        buf_addr_q, buf_addr_d;
  logic                start_q, start_d, done_flag_q, done_flag_d, err_flag_q, err_flag_d;
  logic [31:0]         run_cnt_q, run_cnt_d;
  logic [17:0]         boff;
  logic                wr, ctrl_start, ctrl_clear;
  always_comb begin
    hdr   = bus.rx.c0.hdr;
    boff  = {hdr.address[15:1], 3'b000};
    wr    = bus.rx.c0.mmioWrValid;
    wmask = csr_wmask(hdr.length, hdr.address[0]);
    // 4B data is replicated into both halves so the mask alone selects the target half
    wval  = hdr.length == 2'd0 ? {2{bus.rx.c0.data[31:0]}} : bus.rx.c0.data;
    case (boff)
      CSR_DFH:      rd_data = AFU_DFH;
      CSR_ID_L:     rd_data = AFU_ID[63:0];
      CSR_ID_H:     rd_data = AFU_ID[127:64];
      CSR_SCRATCH:  rd_data = scratch_q;
      CSR_BUF_ADDR: rd_data = {22'b0, buf_addr_q};
      CSR_STATUS:   rd_data = {run_cnt_q, 29'b0, err_flag_q, done_flag_q, busy};
      default:      rd_data = '0;
    endcase
    scratch_d  = wr && boff == CSR_SCRATCH ? (scratch_q & ~wmask) | (wval & wmask) : scratch_q;
    buf_addr_d = wr && boff == CSR_BUF_ADDR ? (buf_addr_q & ~wmask[41:0]) | (wval[41:0] & wmask[41:0]) : buf_addr_q;
    ctrl_start = wr && boff == CSR_CTRL && wval[CTRL_START] && wmask[CTRL_START];
    ctrl_clear = wr && boff == CSR_CTRL && wval[CTRL_CLEAR] && wmask[CTRL_CLEAR];
    start_d     = ctrl_start && !busy;
    // Clear is applied first so a same-cycle done or rejected start still lands
    done_flag_d = done || (done_flag_q && !ctrl_clear);
    err_flag_d  = (ctrl_start && busy) || (err_flag_q && !ctrl_clear);
    run_cnt_d   = (ctrl_clear ? 32'h0 : run_cnt_q) + {31'b0, done};
    tx_d.mmioRdValid = bus.rx.c0.mmioRdValid;
    tx_d.hdr.tid     = bus.rx.c0.mmioRdValid ? hdr.tid : tx_q.hdr.tid;
    tx_d.data        = bus.rx.c0.mmioRdValid ? rd_data : tx_q.data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q        <= '0;
      scratch_q   <= '0;
      buf_addr_q  <= '0;
      start_q     <= 1'b0;
      done_flag_q <= 1'b0;
      err_flag_q  <= 1'b0;
      run_cnt_q   <= '0;
    end else begin
      tx_q        <= tx_d;
      scratch_q   <= scratch_d;
      buf_addr_q  <= buf_addr_d;
      start_q     <= start_d;
      done_flag_q <= done_flag_d;
      err_flag_q  <= err_flag_d;
      run_cnt_q   <= run_cnt_d;
    end
  end
  assign bus.tx_c2 = tx_q;
  assign buf_addr  = buf_addr_q;
  assign start     = start_q;
endmodule

// File: tb/tb_afu_csr.sv
// tb_afu_csr: randomized scoreboard bench for afu_csr against a register-map reference model
module tb_afu_csr;
  import afu_csr_pkg::*;
  localparam logic [127:0] ID  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [63:0]  DFH = 64'h1000_0000_0000_0000;
  logic         clk = 1'b0, rst_n = 1'b1, busy = 1'b0, done = 1'b0, start;
  t_ccip_clAddr buf_addr;
  afu_csr_if bus();
  afu_csr #(.AFU_ID(ID), .AFU_DFH(DFH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .buf_addr(buf_addr), .start(start), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct { logic [8:0] tid; logic [63:0] data; } rsp_t;
  rsp_t        rd_q[$];
  logic        st_q[$];
  int          n_vec = 0, n_err = 0;
  logic [63:0] m_scratch;
  logic [41:0] m_buf;
  logic        m_done, m_err;
  logic [31:0] m_cnt;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] reg_val(input logic [15:0] a, input logic b);
    case (a[15:1])
      15'd0:   return DFH;
      15'd1:   return ID[63:0];
      15'd2:   return ID[127:64];
      15'd5:   return m_scratch;
      15'd6:   return {22'b0, m_buf};
      15'd8:   return {m_cnt, 29'b0, m_err, m_done, b};
      default: return 64'h0;
    endcase
  endfunction
  function automatic logic [63:0] put(input logic [63:0] old, input logic [63:0] d, input logic [1:0] len, input logic hi);
    if (len != 2'd0) return d;
    return hi ? {d[31:0], old[31:0]} : {old[63:32], d[31:0]};
  endfunction
  task automatic model_reset();
    m_scratch = '0; m_buf = '0; m_done = 0; m_err = 0; m_cnt = '0;
    rd_q.delete(); st_q.delete();
  endtask
  task automatic step(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] len,
                      input logic [63:0] d, input logic [8:0] tid, input logic b, input logic dn);
    logic [63:0] tmp;
    logic [1:0]  c;
    @(negedge clk);
    bus.rx.c0.mmioRdValid = rd;
    bus.rx.c0.mmioWrValid = wr;
    bus.rx.c0.hdr.address = a;
    bus.rx.c0.hdr.length  = len;
    bus.rx.c0.hdr.tid     = tid;
    bus.rx.c0.data        = d;
    busy = b;
    done = dn;
    if (rd) rd_q.push_back('{tid, reg_val(a, b)});
    c = 2'b00;
    if (wr) begin
      if (a[15:1] == 15'd5) m_scratch = put(m_scratch, d, len, a[0]);
      if (a[15:1] == 15'd6) begin
        tmp = put({22'b0, m_buf}, d, len, a[0]);
        m_buf = tmp[41:0];
      end
      if (a[15:1] == 15'd7) c = (len == 2'd0 && a[0]) ? 2'b00 : d[1:0];
    end
    if (c[1]) begin m_done = 0; m_err = 0; m_cnt = 0; end
    if (c[0] && b) m_err = 1;
    if (dn) begin m_done = 1; m_cnt = m_cnt + 1; end
    st_q.push_back(c[0] && !b);
  endtask
  task automatic rd(input logic [15:0] a, input logic [8:0] tid, input logic b = 0, input logic dn = 0);
    step(1, 0, a, 2'd1, '0, tid, b, dn);
  endtask
  task automatic wr(input logic [15:0] a, input logic [1:0] len, input logic [63:0] d, input logic b = 0, input logic dn = 0);
    step(0, 1, a, len, d, '0, b, dn);
  endtask
  task automatic idle(input logic b = 0, input logic dn = 0);
    step(0, 0, '0, '0, '0, '0, b, dn);
  endtask
  task automatic sweep(input logic b);
    for (int i = 0; i < 9; i++) rd(16'(2 * i), 9'(i + 100), b);
    idle(b);
  endtask
  always @(posedge clk) begin
    rsp_t r;
    #1;
    if (rst_n) begin
      if (bus.tx_c2.mmioRdValid) begin
        if (rd_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got tid %h with no read outstanding", bus.tx_c2.hdr.tid);
        end else begin
          r = rd_q.pop_front();
          check("rsp_tid", 64'(bus.tx_c2.hdr.tid), 64'(r.tid));
          check("rsp_data", bus.tx_c2.data, r.data);
        end
      end
      if (st_q.size() != 0) check("start", 64'(start), 64'(st_q.pop_front()));
      check("buf_addr", 64'(buf_addr), 64'(m_buf));
    end
  end
  initial begin
    bus.rx = '0;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd_valid", 64'(bus.tx_c2.mmioRdValid), 64'h0);
    check("rst_tid", 64'(bus.tx_c2.hdr.tid), 64'h0);
    check("rst_data", bus.tx_c2.data, 64'h0);
    check("rst_start", 64'(start), 64'h0);
    check("rst_buf_addr", 64'(buf_addr), 64'h0);
    rst_n = 1'b1;
    rd(16'h0, 9'd5); rd(16'h2, 9'd6); rd(16'h4, 9'd7); idle();
    wr(16'hA, 2'd1, 64'hDEAD_BEEF_0123_4567); wr(16'hB, 2'd0, 64'hAAAA_AAAA); rd(16'hA, 9'd8); idle();
    wr(16'hC, 2'd1, 64'h1234); wr(16'hE, 2'd1, 64'h1); idle(); idle();
    wr(16'hE, 2'd1, 64'h1, 1); rd(16'h10, 9'd9, 1); idle();
    wr(16'hE, 2'd1, 64'h2);
    idle(0, 1); idle(); idle(0, 1); idle(0, 1); rd(16'h10, 9'd10); idle();
    wr(16'hE, 2'd1, 64'h2, 0, 1); rd(16'h10, 9'd11); idle();
    rd(16'h40, 9'd12); wr(16'h40, 2'd1, '1); sweep(0);
    for (int i = 0; i < 600; i++) begin
      int op;
      logic [15:0] a;
      op = $urandom_range(0, 2);
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 19));
      step(op == 1, op == 2, a, 2'($urandom_range(0, 3)), {$urandom, $urandom}, 9'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0);
    end
    sweep(0);
    wr(16'hA, 2'd1, 64'h55); wr(16'hC, 2'd1, 64'h77); idle(0, 1);
    rd(16'h10, 9'h33);
    @(posedge clk);
    #3 rst_n = 1'b0;
    bus.rx = '0;
    #1 check("rst_async_valid", 64'(bus.tx_c2.mmioRdValid), 64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    sweep(0);
    idle(); idle();
    check("rd_q_drained", 64'(rd_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
